// File: rtl/rtla_pkg.sv
// Shared definitions for the capture dump path: sync bytes, FSM encodings, word/byte helper.
package rtla_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] SYNC0 = 8'h52;
  localparam logic [BYTE_W-1:0] SYNC1 = 8'h54;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR0  = 3'd1,
    ST_HDR1  = 3'd2,
    ST_FETCH = 3'd3,
    ST_LOAD  = 3'd4,
    ST_SEND  = 3'd5,
    ST_CSUM  = 3'd6,
    ST_REARM = 3'd7
  } dump_state_t;

  typedef enum logic [1:0] {
    ISS_IDLE  = 2'd0,
    ISS_GUARD = 2'd1,
    ISS_WAIT  = 2'd2
  } iss_state_t;

  function automatic int unsigned bytes_per_word(input int unsigned data_width);
    return data_width / BYTE_W;
  endfunction

endpackage

// File: rtl/capture_dump_uart_if.sv
// Bundle of capture-core read port, UART byte port and frame status for the dump block.
interface capture_dump_uart_if
  import rtla_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH = 9
);

  logic                  done;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  capture_rearm;
  logic [BYTE_W-1:0]     tx_data;
  logic                  tx_en;
  logic                  tx_active;
  logic                  busy;
  logic [BYTE_W-1:0]     checksum_out;

  modport master (
    input  done, read_data, tx_active,
    output read_addr, capture_rearm, tx_data, tx_en, busy, checksum_out
  );

  modport slave (
    output done, read_data, tx_active,
    input  read_addr, capture_rearm, tx_data, tx_en, busy, checksum_out
  );

endinterface

// File: rtl/uart_byte_issuer.sv
// Paces bytes into the UART: one-cycle tx_en strobe, a guard cycle, then wait for tx_active low.
module uart_byte_issuer
  import rtla_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              ack,
  input  logic              tx_active,
  output logic              tx_en,
  output logic [BYTE_W-1:0] tx_data
);

  iss_state_t state;

  // Guard cycle covers the UART's one-cycle delay before it raises tx_active.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ISS_IDLE;
      ack     <= 1'b0;
      tx_en   <= 1'b0;
      tx_data <= '0;
    end else begin
      ack   <= 1'b0;
      tx_en <= 1'b0;
      case (state)
        ISS_IDLE: begin
          if (req && !tx_active) begin
            tx_en   <= 1'b1;
            tx_data <= byte_in;
            ack     <= 1'b1;
            state   <= ISS_GUARD;
          end
        end
        ISS_GUARD: state <= ISS_WAIT;
        ISS_WAIT:  if (!tx_active) state <= ISS_IDLE;
        default:   state <= ISS_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/capture_dump_uart.sv
// Streams the capture buffer to the UART as "RT" + words (MSB byte first) + XOR checksum,
// then pulses capture_rearm to re-arm the capture core.
module capture_dump_uart
  import rtla_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 128,
  parameter int unsigned ADDR_WIDTH   = 9,
  parameter int unsigned DEPTH        = 512,
  parameter int unsigned READ_LATENCY = 1
)(
  input  logic                 clk,
  input  logic                 reset,
  capture_dump_uart_if.master  bus
);

  localparam int unsigned BPW    = bytes_per_word(DATA_WIDTH);
  localparam int unsigned BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned LAT_W  = 2;

  dump_state_t           state;
  logic                  done_q;
  logic [LAT_W-1:0]      lat_cnt;
  logic [BIDX_W-1:0]     byte_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  req;
  logic [BYTE_W-1:0]     req_byte;
  logic                  ack;

  uart_byte_issuer u_issuer (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .byte_in   (req_byte),
    .ack       (ack),
    .tx_active (bus.tx_active),
    .tx_en     (bus.tx_en),
    .tx_data   (bus.tx_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= ST_IDLE;
      done_q            <= 1'b0;
      lat_cnt           <= '0;
      byte_idx          <= '0;
      shreg             <= '0;
      req               <= 1'b0;
      req_byte          <= '0;
      bus.read_addr     <= '0;
      bus.capture_rearm <= 1'b0;
      bus.busy          <= 1'b0;
      bus.checksum_out  <= '0;
    end else begin
      done_q            <= bus.done;
      bus.capture_rearm <= 1'b0;
      // A data byte accepted by the issuer counts even if the frame aborts this edge.
      if (ack && state == ST_SEND) bus.checksum_out <= bus.checksum_out ^ req_byte;

      if (bus.busy && state != ST_REARM && !bus.done) begin
        state         <= ST_IDLE;
        req           <= 1'b0;
        bus.busy      <= 1'b0;
        bus.read_addr <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.done && !done_q) begin
              state            <= ST_HDR0;
              bus.busy         <= 1'b1;
              bus.checksum_out <= '0;
              bus.read_addr    <= '0;
              req              <= 1'b1;
              req_byte         <= SYNC0;
            end
          end
          ST_HDR0: begin
            if (ack) begin
              req_byte <= SYNC1;
              state    <= ST_HDR1;
            end
          end
          ST_HDR1: begin
            if (ack) begin
              req     <= 1'b0;
              lat_cnt <= '0;
              state   <= ST_FETCH;
            end
          end
          ST_FETCH: begin
            if (lat_cnt == LAT_W'(READ_LATENCY - 1)) state <= ST_LOAD;
            else lat_cnt <= lat_cnt + LAT_W'(1);
          end
          ST_LOAD: begin
            req_byte <= bus.read_data[DATA_WIDTH-1 -: BYTE_W];
            shreg    <= bus.read_data << BYTE_W;
            byte_idx <= '0;
            req      <= 1'b1;
            state    <= ST_SEND;
          end
          ST_SEND: begin
            if (ack) begin
              if (byte_idx == BIDX_W'(BPW - 1)) begin
                if (bus.read_addr == ADDR_WIDTH'(DEPTH - 1)) begin
                  req_byte <= bus.checksum_out ^ req_byte;
                  state    <= ST_CSUM;
                end else begin
                  req           <= 1'b0;
                  bus.read_addr <= bus.read_addr + ADDR_WIDTH'(1);
                  lat_cnt       <= '0;
                  state         <= ST_FETCH;
                end
              end else begin
                byte_idx <= byte_idx + BIDX_W'(1);
                req_byte <= shreg[DATA_WIDTH-1 -: BYTE_W];
                shreg    <= shreg << BYTE_W;
              end
            end
          end
          ST_CSUM: begin
            if (ack) begin
              req               <= 1'b0;
              bus.capture_rearm <= 1'b1;
              state             <= ST_REARM;
            end
          end
          ST_REARM: begin
            bus.read_addr <= '0;
            bus.busy      <= 1'b0;
            state         <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_capture_dump_uart.sv
// Scoreboard bench for capture_dump_uart: latency-1 and latency-3 instances, RAM and UART models.
module tb_capture_dump_uart;
  import rtla_pkg::*;

  localparam int unsigned DW        = 32;
  localparam int unsigned AW        = 3;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned NB        = DW / 8;
  localparam int unsigned FRAME_LEN = 2 + DEPTH * NB + 1;

  localparam logic [7:0] FRAME [FRAME_LEN] = '{
    8'h52, 8'h54,
    8'h00, 8'h00, 8'h00, 8'h00,
    8'h01, 8'h01, 8'h01, 8'h01,
    8'h02, 8'h02, 8'h02, 8'h02,
    8'h03, 8'h03, 8'h03, 8'h03,
    8'h00
  };

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic done1 = 1'b0;
  logic done3 = 1'b0;
  logic hold1 = 1'b0;
  logic [3:0] cnt1, cnt3;
  logic [1:0] hist1 = 2'b00;
  logic [1:0] hist3 = 2'b00;
  logic [DW-1:0] pipe3a, pipe3b;
  logic [7:0] exp1 [$];
  logic [7:0] exp3 [$];
  int n_checks = 0;
  int n_fail   = 0;
  int sent1 = 0, sent3 = 0, rearm1 = 0, rearm3 = 0;

  always #5 clk = ~clk;

  capture_dump_uart_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();
  capture_dump_uart_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus3 ();

  capture_dump_uart #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.master));
  capture_dump_uart #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3.master));

  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    logic [7:0] b;
    b = 8'(a);
    return {NB{b}};
  endfunction

  // Capture RAM models: one-cycle and three-cycle read latency
  always @(posedge clk) bus1.read_data <= ram_word(bus1.read_addr);
  always @(posedge clk) begin
    pipe3a         <= ram_word(bus3.read_addr);
    pipe3b         <= pipe3a;
    bus3.read_data <= pipe3b;
  end

  // UART models: busy from the cycle after tx_en for 10 cycles
  always @(posedge clk or posedge reset)
    if (reset) cnt1 <= '0;
    else if (bus1.tx_en) cnt1 <= 4'd10;
    else if (cnt1 != 4'd0) cnt1 <= cnt1 - 4'd1;
  always @(posedge clk or posedge reset)
    if (reset) cnt3 <= '0;
    else if (bus3.tx_en) cnt3 <= 4'd10;
    else if (cnt3 != 4'd0) cnt3 <= cnt3 - 4'd1;

  assign bus1.tx_active = (cnt1 != 4'd0) || hold1;
  assign bus3.tx_active = (cnt3 != 4'd0);
  assign bus1.done      = done1;
  assign bus3.done      = done3;

  task automatic check(input logic ok, input string name, input int act, input int req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin : mon1
    logic [7:0] e;
    if (!reset) begin
      if (bus1.tx_en) begin
        check(hist1 == 2'b00 && !bus1.tx_active, "tx1_spacing", {hist1, bus1.tx_active}, 0);
        check(exp1.size() != 0, "tx1_unexpected_byte", exp1.size(), 1);
        if (exp1.size() != 0) begin
          e = exp1.pop_front();
          check(bus1.tx_data == e, "tx1_byte", bus1.tx_data, e);
        end
        sent1++;
      end
      if (bus1.capture_rearm) rearm1++;
    end
    hist1 = {hist1[0], bus1.tx_en};
  end

  always @(negedge clk) begin : mon3
    logic [7:0] e;
    if (!reset) begin
      if (bus3.tx_en) begin
        check(hist3 == 2'b00 && !bus3.tx_active, "tx3_spacing", {hist3, bus3.tx_active}, 0);
        check(exp3.size() != 0, "tx3_unexpected_byte", exp3.size(), 1);
        if (exp3.size() != 0) begin
          e = exp3.pop_front();
          check(bus3.tx_data == e, "tx3_byte", bus3.tx_data, e);
        end
        sent3++;
      end
      if (bus3.capture_rearm) rearm3++;
    end
    hist3 = {hist3[0], bus3.tx_en};
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_frame(input bit third, input int n);
    for (int i = 0; i < n; i++) begin
      if (third) exp3.push_back(FRAME[i]);
      else exp1.push_back(FRAME[i]);
    end
  endtask

  task automatic wait_sent1(input int target, input string name);
    int i;
    i = 0;
    while (sent1 < target && i < 3000) begin tick(); i++; end
    check(sent1 >= target, name, sent1, target);
  endtask

  task automatic wait_idle1(input string name);
    int i;
    i = 0;
    while (bus1.busy && i < 3000) begin tick(); i++; end
    check(!bus1.busy, name, bus1.busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, sent1=%0d sent3=%0d", sent1, sent3);
    $fatal(1);
  end

  initial begin
    int base, snap, r, i;
    reset = 1'b1;
    tick(); tick();
    check(bus1.busy == 0 && bus1.tx_en == 0 && bus1.capture_rearm == 0, "reset_ctl",
          {bus1.busy, bus1.tx_en, bus1.capture_rearm}, 0);
    check(bus1.read_addr == 0 && bus1.checksum_out == 0 && bus1.tx_data == 0, "reset_data",
          {bus1.read_addr, bus1.checksum_out, bus1.tx_data}, 0);
    reset = 1'b0;
    tick();

    // Full frame on the latency-1 instance
    push_frame(1'b0, FRAME_LEN);
    done1 = 1'b1;
    tick();
    check(bus1.busy == 1, "frame1_busy_rise", bus1.busy, 1);
    wait_idle1("frame1_complete");
    check(rearm1 == 1, "frame1_rearm", rearm1, 1);
    check(sent1 == FRAME_LEN, "frame1_len", sent1, FRAME_LEN);
    check(bus1.checksum_out == 8'h00, "frame1_csum", bus1.checksum_out, 0);
    check(bus1.read_addr == 0, "frame1_addr_rearmed", bus1.read_addr, 0);
    check(exp1.size() == 0, "frame1_drain", exp1.size(), 0);

    // done held high after the frame must not restart
    repeat (100) tick();
    check(sent1 == FRAME_LEN && !bus1.busy, "held_done_no_restart", sent1, FRAME_LEN);
    check(rearm1 == 1, "held_done_rearm", rearm1, 1);

    // Second frame with tx_active forced high mid-word
    done1 = 1'b0;
    repeat (3) tick();
    base = sent1;
    push_frame(1'b0, FRAME_LEN);
    done1 = 1'b1;
    wait_sent1(base + 7, "hold_reach");
    hold1 = 1'b1;
    snap  = sent1;
    repeat (50) tick();
    check(sent1 == snap, "hold_no_tx", sent1, snap);
    check(bus1.busy == 1, "hold_busy", bus1.busy, 1);
    hold1 = 1'b0;
    wait_idle1("frame2_complete");
    check(rearm1 == 2, "frame2_rearm", rearm1, 2);
    check(sent1 == base + FRAME_LEN, "frame2_len", sent1, base + FRAME_LEN);
    check(exp1.size() == 0, "frame2_drain", exp1.size(), 0);

    // Abort after the 7th data byte
    done1 = 1'b0;
    repeat (3) tick();
    base = sent1;
    r    = rearm1;
    push_frame(1'b0, 9);
    done1 = 1'b1;
    wait_sent1(base + 9, "abort_reach");
    done1 = 1'b0;
    repeat (3) tick();
    check(bus1.checksum_out == 8'h01, "abort_csum", bus1.checksum_out, 8'h01);
    check(bus1.busy == 0, "abort_busy", bus1.busy, 0);
    repeat (40) tick();
    check(sent1 == base + 9, "abort_no_tx", sent1, base + 9);
    check(rearm1 == r, "abort_no_rearm", rearm1, r);

    // Asynchronous reset in the middle of word 1
    base = sent1;
    r    = rearm1;
    push_frame(1'b0, 7);
    done1 = 1'b1;
    wait_sent1(base + 7, "rst_reach");
    repeat (2) tick();
    check(bus1.busy == 1 && bus1.read_addr == 3'd1, "pre_reset_state",
          {bus1.busy, bus1.read_addr}, 4'h9);
    #2 reset = 1'b1;
    #1;
    check(bus1.busy == 0 && bus1.tx_en == 0 && bus1.capture_rearm == 0, "async_reset_ctl",
          {bus1.busy, bus1.tx_en, bus1.capture_rearm}, 0);
    check(bus1.read_addr == 0 && bus1.checksum_out == 0 && bus1.tx_data == 0, "async_reset_data",
          {bus1.read_addr, bus1.checksum_out, bus1.tx_data}, 0);
    exp1.delete();
    done1 = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    base = sent1;
    push_frame(1'b0, FRAME_LEN);
    done1 = 1'b1;
    tick();
    check(bus1.busy == 1, "post_reset_busy", bus1.busy, 1);
    wait_idle1("post_reset_complete");
    check(sent1 == base + FRAME_LEN, "post_reset_len", sent1, base + FRAME_LEN);
    check(rearm1 == r + 1, "post_reset_rearm", rearm1, r + 1);
    check(exp1.size() == 0, "post_reset_drain", exp1.size(), 0);

    // Latency-3 instance must produce the identical stream
    check(sent3 == 0 && rearm3 == 0, "lat3_quiet", sent3, 0);
    push_frame(1'b1, FRAME_LEN);
    done3 = 1'b1;
    tick();
    check(bus3.busy == 1, "lat3_busy_rise", bus3.busy, 1);
    i = 0;
    while (bus3.busy && i < 3000) begin tick(); i++; end
    check(!bus3.busy, "lat3_complete", bus3.busy, 0);
    check(sent3 == FRAME_LEN, "lat3_len", sent3, FRAME_LEN);
    check(rearm3 == 1, "lat3_rearm", rearm3, 1);
    check(bus3.checksum_out == 8'h00, "lat3_csum", bus3.checksum_out, 0);
    check(exp3.size() == 0, "lat3_drain", exp3.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
